// File: rtl/cellram_ctrl_pkg.sv
// Shared definitions for the CellRAM async self-test controller.
//   state_e   : controller FSM states
//   pattern() : test word written at index i
//   hex2seg() : hex nibble to active-low segments {g,f,e,d,c,b,a}
//   Led*      : bit positions within the Led status vector
package cellram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRdAccess,
    StRdRecover,
    StPass,
    StFail
  } state_e;

  localparam int unsigned LedDone  = 0;
  localparam int unsigned LedPass  = 1;
  localparam int unsigned LedFail  = 2;
  localparam int unsigned LedBusy  = 3;
  localparam int unsigned LedIdxLo = 4;

  function automatic logic [15:0] pattern(input logic [7:0] i);
    return 16'hA500 | {8'h00, i};
  endfunction

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b100_0000;
      4'h1:    s = 7'b111_1001;
      4'h2:    s = 7'b010_0100;
      4'h3:    s = 7'b011_0000;
      4'h4:    s = 7'b001_1001;
      4'h5:    s = 7'b001_0010;
      4'h6:    s = 7'b000_0010;
      4'h7:    s = 7'b111_1000;
      4'h8:    s = 7'b000_0000;
      4'h9:    s = 7'b001_0000;
      4'hA:    s = 7'b000_1000;
      4'hB:    s = 7'b000_0011;
      4'hC:    s = 7'b100_0110;
      4'hD:    s = 7'b010_0001;
      4'hE:    s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// Four-digit multiplexed seven-segment driver.
//   clk   : system clock
//   sw0   : asynchronous active-low reset
//   value : 16-bit value shown as four hex digits, an[0] = least-significant nibble
//   seg   : {dp, g..a}, active-low, dp always off
//   an    : digit enables, active-low
module seven_seg_mux
  import cellram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        sw0,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned RefW = REFRESH_BITS + 2;

  logic [RefW-1:0] refresh_q;
  logic [1:0]      digit;
  logic [3:0]      nibble;

  // Top two counter bits pick the digit, so each digit is lit 2^REFRESH_BITS clocks.
  assign digit = refresh_q[RefW-1 -: 2];

  always_comb begin
    nibble = value[3:0];
    unique case (digit)
      2'd0: nibble = value[3:0];
      2'd1: nibble = value[7:4];
      2'd2: nibble = value[11:8];
      2'd3: nibble = value[15:12];
      default: nibble = value[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge sw0) begin
    if (!sw0) begin
      refresh_q <= '0;
      an        <= 4'hF;
      seg       <= 8'hFF;
    end else begin
      refresh_q <= refresh_q + RefW'(1);
      an        <= ~(4'b0001 << digit);
      seg       <= {1'b1, hex2seg(nibble)};
    end
  end

endmodule

// File: rtl/cellram_async_controller.sv
// CellRAM asynchronous-mode self-test controller.
// After reset release writes pattern(i) to BASE_ADDR+i for i < NUM_WORDS, reads the block back
// and compares, stopping at the first mismatch.
//   clk, sw0        : 100 MHz clock, asynchronous active-low reset
//   seg, an         : seven-segment display of the last read word
//   Led             : {fail_idx[3:0], busy, fail, pass, done}
//   ADDR, DATA      : CellRAM address and bidirectional data bus
//   MEMnOE, MEMnWR  : output/write enables, active-low
//   RAMnCS/nUB/nLB  : chip select and byte enables, active-low
//   MEMnAdv, MEMClk, RAMCRE : tied low; MEMWait is ignored
module cellram_async_controller
  import cellram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned NUM_WORDS    = 16,
  parameter int unsigned WR_CYCLES    = 8,
  parameter int unsigned RD_CYCLES    = 8,
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        sw0,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [7:0]  Led,
  output logic [25:0] ADDR,
  inout  wire  [15:0] DATA,
  output logic        MEMnOE,
  output logic        MEMnWR,
  output logic        MEMnAdv,
  output logic        MEMClk,
  input  logic        MEMWait,
  output logic        RAMnCS,
  output logic        RAMnUB,
  output logic        RAMnLB,
  output logic        RAMCRE
);

  localparam logic [15:0] WrLast  = 16'(WR_CYCLES - 1);
  localparam logic [15:0] RdLast  = 16'(RD_CYCLES - 1);
  localparam logic [7:0]  IdxLast = 8'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  fail_idx_q, fail_idx_d;
  logic [15:0] rd_data_q;
  logic        mismatch_q;
  logic [15:0] data_out_q;
  logic        data_oe_q;

  logic        last_word;
  logic        sample_en;
  logic        wr_phase;
  logic        rd_phase;
  logic [25:0] addr_d;
  logic [7:0]  led_d;
  logic        unused_memwait;

  assign unused_memwait = MEMWait;

  assign MEMnAdv = 1'b0;
  assign MEMClk  = 1'b0;
  assign RAMCRE  = 1'b0;

  assign DATA = data_oe_q ? data_out_q : 16'hzzzz;

  assign last_word = (idx_q == IdxLast);
  assign sample_en = (state_q == StRdAccess) && (cnt_q == RdLast);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    fail_idx_d = fail_idx_q;
    unique case (state_q)
      StIdle: begin
        state_d    = StWrSetup;
        idx_d      = '0;
        fail_idx_d = '0;
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = '0;
      end
      StWrPulse: begin
        if (cnt_q == WrLast) state_d = StWrHold;
        else                 cnt_d   = cnt_q + 16'd1;
      end
      StWrHold: begin
        if (last_word) begin
          state_d = StRdAccess;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StWrSetup;
          idx_d   = idx_q + 8'd1;
        end
      end
      StRdAccess: begin
        if (cnt_q == RdLast) state_d = StRdRecover;
        else                 cnt_d   = cnt_q + 16'd1;
      end
      StRdRecover: begin
        if (mismatch_q) begin
          state_d    = StFail;
          fail_idx_d = idx_q;
        end else if (last_word) begin
          state_d = StPass;
        end else begin
          state_d = StRdAccess;
          idx_d   = idx_q + 8'd1;
          cnt_d   = '0;
        end
      end
      StPass, StFail: begin
        state_d = state_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and status values for the upcoming state; registering them keeps every output aligned
  // with the state register and glitch-free at the pins.
  always_comb begin
    wr_phase = state_d inside {StWrSetup, StWrPulse, StWrHold};
    rd_phase = state_d inside {StRdAccess, StRdRecover};
    addr_d   = ADDR;
    if (wr_phase || rd_phase) addr_d = 26'(BASE_ADDR) + 26'(idx_d);
    led_d                  = '0;
    led_d[LedDone]         = (state_d == StPass) || (state_d == StFail);
    led_d[LedPass]         = (state_d == StPass);
    led_d[LedFail]         = (state_d == StFail);
    led_d[LedBusy]         = wr_phase || rd_phase;
    led_d[LedIdxLo +: 4]   = (state_d == StFail) ? fail_idx_d[3:0] : 4'h0;
  end

  always_ff @(posedge clk or negedge sw0) begin
    if (!sw0) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      fail_idx_q <= '0;
      rd_data_q  <= '0;
      mismatch_q <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ADDR       <= '0;
      MEMnOE     <= 1'b1;
      MEMnWR     <= 1'b1;
      RAMnCS     <= 1'b1;
      RAMnUB     <= 1'b1;
      RAMnLB     <= 1'b1;
      Led        <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      fail_idx_q <= fail_idx_d;
      data_out_q <= pattern(idx_d);
      data_oe_q  <= wr_phase;
      ADDR       <= addr_d;
      MEMnOE     <= !(state_d == StRdAccess);
      MEMnWR     <= !(state_d == StWrPulse);
      RAMnCS     <= !(wr_phase || rd_phase);
      RAMnUB     <= !(wr_phase || rd_phase);
      RAMnLB     <= !(wr_phase || rd_phase);
      Led        <= led_d;
      if (sample_en) begin
        rd_data_q  <= DATA;
        mismatch_q <= (DATA != pattern(idx_q));
      end
    end
  end

  seven_seg_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_seven_seg_mux (
    .clk  (clk),
    .sw0  (sw0),
    .value(rd_data_q),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_cellram_async_controller.sv
// Self-checking bench: a behavioural CellRAM with per-address read corruption, randomized
// corruption sets and reset timing, checked against outcome/timing derived from the test rules.
module tb_cellram_async_controller;

  localparam int unsigned NumWords    = 16;
  localparam int unsigned WrCycles    = 8;
  localparam int unsigned RdCycles    = 8;
  localparam int unsigned RefreshBits = 2;
  localparam int          Budget      = 3000;

  logic        clk = 1'b0;
  logic        sw0 = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [7:0]  Led;
  logic [25:0] ADDR;
  wire  [15:0] DATA;
  logic        MEMnOE, MEMnWR, MEMnAdv, MEMClk;
  logic        MEMWait = 1'b0;
  logic        RAMnCS, RAMnUB, RAMnLB, RAMCRE;

  logic [15:0] mem   [256];
  logic [15:0] cmask [256];
  wire         model_oe;
  wire  [15:0] model_q;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Memory drives the bus while selected with output enable low; cmask corrupts reads.
  assign model_oe = !RAMnCS && !MEMnOE;
  assign model_q  = mem[ADDR[7:0]] ^ cmask[ADDR[7:0]];
  assign DATA     = model_oe ? model_q : 16'hzzzz;

  always #5 clk = ~clk;

  cellram_async_controller #(
    .BASE_ADDR   (0),
    .NUM_WORDS   (NumWords),
    .WR_CYCLES   (WrCycles),
    .RD_CYCLES   (RdCycles),
    .REFRESH_BITS(RefreshBits)
  ) dut (
    .clk    (clk),
    .sw0    (sw0),
    .seg    (seg),
    .an     (an),
    .Led    (Led),
    .ADDR   (ADDR),
    .DATA   (DATA),
    .MEMnOE (MEMnOE),
    .MEMnWR (MEMnWR),
    .MEMnAdv(MEMnAdv),
    .MEMClk (MEMClk),
    .MEMWait(MEMWait),
    .RAMnCS (RAMnCS),
    .RAMnUB (RAMnUB),
    .RAMnLB (RAMnLB),
    .RAMCRE (RAMCRE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} for a hex digit.
  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] word_of(input int i);
    return 16'hA500 | 16'(i);
  endfunction

  task automatic check_display(input logic [15:0] val);
    logic [3:0] prev_an;
    int         seen [4];
    int         d;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    prev_an = an;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) begin
        check("an_onehot", {28'h0, an}, 32'hE);
      end else begin
        seen[d]++;
        check($sformatf("seg_digit%0d", d), {24'h0, seg}, {24'h0, 1'b1, seg_of(val[4*d +: 4])});
        if (an != prev_an) check("an_step", {28'h0, an}, {28'h0, prev_an[2:0], prev_an[3]});
      end
      prev_an = an;
    end
    for (int i = 0; i < 4; i++) check($sformatf("an_dwell%0d", i), seen[i], 4);
  endtask

  task automatic mid_write_reset();
    int r;
    sw0 = 1'b0;
    repeat (3) @(negedge clk);
    sw0 = 1'b1;
    r = $urandom_range(1, WrCycles);
    // Third write: setup after edge 2*(W+2)+1, pulse on the following W edges.
    repeat (2 * (WrCycles + 2) + 1 + r) @(negedge clk);
    check("mid_pre_nwr", {31'h0, MEMnWR}, 0);
    check("mid_pre_addr", {6'h0, ADDR}, 2);
    #2 sw0 = 1'b0;
    #1;
    check("mid_nwr", {31'h0, MEMnWR}, 1);
    check("mid_ncs", {31'h0, RAMnCS}, 1);
    check("mid_data_z", {16'h0, DATA}, {16'h0, 16'hzzzz});
    check("mid_addr", {6'h0, ADDR}, 0);
    check("mid_led", {24'h0, Led}, 0);
  endtask

  task automatic run_trial(input int t);
    int          kexp, k, c, reads, nwr_low, done_c, extra, exp_c;
    logic        prev_oe, wr_ok, tied_ok;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;

    for (int a = 0; a < 256; a++) begin
      mem[a]   = 16'($urandom);
      cmask[a] = 16'h0;
    end
    if (t == 1) begin
      cmask[5] = 16'($urandom_range(1, 65535));
    end else if (t >= 2) begin
      for (int i = 0; i < NumWords; i++)
        if ($urandom_range(0, 5) == 0) cmask[i] = 16'($urandom_range(1, 65535));
    end
    kexp = -1;
    for (int i = 0; i < NumWords; i++) if (kexp < 0 && cmask[i] != 16'h0) kexp = i;
    k       = (kexp < 0) ? NumWords - 1 : kexp;
    exp_c   = 1 + NumWords * (WrCycles + 2) + (k + 1) * (RdCycles + 1);
    exp_rd  = word_of(k) ^ cmask[k];
    exp_led = (kexp < 0) ? 8'b0000_0011 : {4'(k), 4'b0101};

    sw0 = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("rst_ctrl", {27'h0, MEMnOE, MEMnWR, RAMnCS, RAMnUB, RAMnLB}, 32'h1F);
    check("rst_data_z", {16'h0, DATA}, {16'h0, 16'hzzzz});
    check("rst_addr", {6'h0, ADDR}, 0);
    check("rst_led", {24'h0, Led}, 0);
    check("rst_an_seg", {20'h0, an, seg}, 32'hFFF);
    check("rst_tied", {29'h0, MEMnAdv, MEMClk, RAMCRE}, 0);
    sw0 = 1'b1;

    reads = 0; nwr_low = 0; wr_ok = 1'b1; tied_ok = 1'b1; prev_oe = 1'b1; done_c = 0; c = 0;
    while (c < Budget && done_c == 0) begin
      @(negedge clk);
      c++;
      if (!RAMnCS && !MEMnWR) mem[ADDR[7:0]] = DATA;
      if (prev_oe && !MEMnOE) reads++;
      prev_oe = MEMnOE;
      if (MEMnAdv || MEMClk || RAMCRE) tied_ok = 1'b0;
      if (c <= WrCycles + 2) begin
        if (ADDR != 26'd0 || DATA !== 16'hA500 || RAMnCS || RAMnUB || RAMnLB || !MEMnOE)
          wr_ok = 1'b0;
        if (!MEMnWR) nwr_low++;
        if (c == 1) check("wr0_setup_nwr", {31'h0, MEMnWR}, 1);
        if (c == WrCycles + 2) check("wr0_hold_nwr", {31'h0, MEMnWR}, 1);
      end
      if (c == WrCycles + 3) begin
        check("wr1_addr", {6'h0, ADDR}, 1);
        check("wr1_data", {16'h0, DATA}, 32'hA501);
      end
      if (Led[0]) done_c = c;
    end

    check($sformatf("t%0d_done", t), {31'h0, Led[0]}, 1);
    check($sformatf("t%0d_cycles", t), done_c, exp_c);
    check($sformatf("t%0d_led", t), {24'h0, Led}, {24'h0, exp_led});
    check($sformatf("t%0d_reads", t), reads, k + 1);
    check("wr0_stable", {31'h0, wr_ok}, 1);
    check("wr0_nwr_low", nwr_low, WrCycles);
    check("tied_low", {31'h0, tied_ok}, 1);
    check("end_bus_idle", {27'h0, MEMnOE, MEMnWR, RAMnCS, RAMnUB, RAMnLB}, 32'h1F);
    check("end_data_z", {16'h0, DATA}, {16'h0, 16'hzzzz});

    extra = 0;
    prev_oe = MEMnOE;
    repeat (20) begin
      @(negedge clk);
      if (prev_oe && !MEMnOE) extra++;
      prev_oe = MEMnOE;
    end
    check("no_more_reads", extra, 0);
    check("led_hold", {24'h0, Led}, {24'h0, exp_led});
    check_display(exp_rd);
  endtask

  initial begin
    for (int t = 0; t < 6; t++) begin
      if (t == 2) mid_write_reset();
      run_trial(t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
